// File: rtl/alu_iterative.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_iterative
//
// Execute-stage ALU. Non-shift operations complete in a single cycle. Shifts
// (SLL/SRL/SRA) walk an accumulator one bit per cycle, so a shift by k costs
// 1 + k cycles. The result, zero flag and illegal flag are registered together
// and presented over a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (forces IDLE, clears result)
//   in_valid   request present on aluselect/in1/in2
//   in_ready   block accepts a request this cycle
//   aluselect  4-bit operation code (see OP_* below)
//   in1        operand A (LUI immediate for In1_To_Out)
//   in2        operand B; low $clog2(XLEN) bits are the shift amount
//   out_valid  result/zero/illegal are valid
//   out_ready  consumer takes the result this cycle
//   result     registered operation result
//   zero       registered (result == 0)
//   illegal    registered flag, set for codes 14 and 15
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The input side is sampled only on that edge; in_ready is high in IDLE,
// or in DONE when the held result is being taken in the same cycle, and low
// while shifting or under reset. out_valid stays high, with result/zero/
// illegal stable, until the edge where out_ready is high.
// ----------------------------------------------------------------------------
module alu_iterative #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      aluselect,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic [1:0]      dbg_state
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_SLL    = 4'd2;
   localparam logic [3:0] OP_SRL    = 4'd3;
   localparam logic [3:0] OP_SRA    = 4'd4;
   localparam logic [3:0] OP_AND    = 4'd5;
   localparam logic [3:0] OP_OR     = 4'd6;
   localparam logic [3:0] OP_XOR    = 4'd7;
   localparam logic [3:0] OP_SLT_S  = 4'd8;
   localparam logic [3:0] OP_SLT_U  = 4'd9;
   localparam logic [3:0] OP_EQ     = 4'd10;
   localparam logic [3:0] OP_SGTE_S = 4'd11;
   localparam logic [3:0] OP_SGTE_U = 4'd12;
   localparam logic [3:0] OP_IN1    = 4'd13;

   // Marker returned for unused/debug codes, fitted to the datapath width.
   localparam logic [XLEN-1:0] ILLEGAL_VALUE = XLEN'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_LEFT        = 2'd0,
      SH_RIGHT_LOGIC = 2'd1,
      SH_RIGHT_ARITH = 2'd2
   } shift_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e            state_q,     state_d;
   logic [XLEN-1:0]   acc_q,       acc_d;
   logic [SHW-1:0]    cnt_q,       cnt_d;
   shift_e            sop_q,       sop_d;
   logic [XLEN-1:0]   result_q,    result_d;
   logic              zero_q,      zero_d;
   logic              illegal_q,   illegal_d;
   logic              out_valid_q, out_valid_d;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic            accept;
   logic [SHW-1:0]  shamt;
   logic            is_shift;
   shift_e          req_sop;

   assign in_ready = !rst && ((state_q == ST_IDLE) ||
                              ((state_q == ST_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign shamt    = in2[SHW-1:0];

   always_comb begin
      is_shift = 1'b0;
      req_sop  = SH_LEFT;
      case (aluselect)
         OP_SLL: begin
            is_shift = 1'b1;
            req_sop  = SH_LEFT;
         end
         OP_SRL: begin
            is_shift = 1'b1;
            req_sop  = SH_RIGHT_LOGIC;
         end
         OP_SRA: begin
            is_shift = 1'b1;
            req_sop  = SH_RIGHT_ARITH;
         end
         default: begin
            is_shift = 1'b0;
            req_sop  = SH_LEFT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Single-cycle datapath. Shift codes only reach this path with shamt == 0,
   // where the answer is in1 unchanged.
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (aluselect)
         OP_ADD:    alu_res = in1 + in2;
         OP_SUB:    alu_res = in1 - in2;
         OP_SLL,
         OP_SRL,
         OP_SRA:    alu_res = in1;
         OP_AND:    alu_res = in1 & in2;
         OP_OR:     alu_res = in1 | in2;
         OP_XOR:    alu_res = in1 ^ in2;
         OP_SLT_S:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) <  $signed(in2))};
         OP_SLT_U:  alu_res = {{(XLEN-1){1'b0}}, (in1 <  in2)};
         OP_EQ:     alu_res = {{(XLEN-1){1'b0}}, (in1 == in2)};
         OP_SGTE_S: alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) >= $signed(in2))};
         OP_SGTE_U: alu_res = {{(XLEN-1){1'b0}}, (in1 >= in2)};
         OP_IN1:    alu_res = in1;
         default: begin
            alu_res = ILLEGAL_VALUE;
            alu_ill = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // One-bit shift step on the accumulator, direction from the latched op.
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] acc_step;

   always_comb begin
      acc_step = acc_q;
      case (sop_q)
         SH_LEFT:        acc_step = {acc_q[XLEN-2:0], 1'b0};
         SH_RIGHT_LOGIC: acc_step = {1'b0, acc_q[XLEN-1:1]};
         SH_RIGHT_ARITH: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default:        acc_step = acc_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sop_d       = sop_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            acc_d = acc_step;
            cnt_d = cnt_q - SHW'(1);
            // cnt == 1 means this step produces the final shifted value.
            if (cnt_q == SHW'(1)) begin
               result_d    = acc_step;
               zero_d      = (acc_step == '0);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      // A new request overrides the DONE->IDLE drain, giving back-to-back
      // issue when the consumer takes the previous result in the same cycle.
      if (accept) begin
         if (is_shift && (shamt != '0)) begin
            acc_d       = in1;
            cnt_d       = shamt;
            sop_d       = req_sop;
            out_valid_d = 1'b0;
            state_d     = ST_SHIFT;
         end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sop_q       <= SH_LEFT;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sop_q       <= sop_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_iterative.sv
`timescale 1ns/1ps
module tb_alu_iterative;

  localparam int XLEN = 32;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      aluselect;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic [1:0]      dbg_state;

  int tests_run;
  int tests_failed;

  logic [XLEN-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_iterative #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluselect (aluselect),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model: plain arithmetic on the operation rules
  // --------------------------------------------------------------------------
  function automatic void model(input logic [3:0] sel, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic ill, output int lat);
    logic [4:0] sh;
    sh  = b[4:0];
    ill = 1'b0;
    lat = 1;
    case (sel)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  begin r = a << sh; lat = 1 + int'(sh); end
      4'd3:  begin r = a >> sh; lat = 1 + int'(sh); end
      4'd4:  begin r = $signed(a) >>> sh; lat = 1 + int'(sh); end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = (a == b) ? 32'd1 : 32'd0;
      4'd11: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd12: r = (a >= b) ? 32'd1 : 32'd0;
      4'd13: r = a;
      default: begin r = 32'hDEADBEEF; ill = 1'b1; end
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Driver: issue one op from IDLE, scramble inputs while busy, hold the
  // result for 'stall' cycles, then take it. Returns what was presented and
  // the number of edges from the accept edge to out_valid.
  // --------------------------------------------------------------------------
  task automatic do_op(input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int stall,
                       output logic [31:0] res, output logic ill,
                       output logic z, output int lat);
    int waited;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluselect = sel;
    in1       = a;
    in2       = b;
    waited    = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid  = 1'($urandom_range(0, 1));
      aluselect = 4'($urandom_range(0, 15));
      in1       = $urandom;
      in2       = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    res = result;
    ill = illegal;
    z   = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluselect = 4'd0;
    in1       = '0;
    in2       = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (result !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want 00000000", result);
    end
    tests_run++;
    if (zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_zero: got %b want 1", zero);
    end
    tests_run++;
    if (illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_illegal: got %b want 0", illegal);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  sel_t[3];
    logic [31:0] a_t[3];
    logic [31:0] b_t[3];
    logic [31:0] res, er;
    logic        ill, z, eill;
    int          lat, elat;
    sel_t[0] = 4'd4; a_t[0] = 32'h80000000; b_t[0] = 32'd31;
    sel_t[1] = 4'd3; a_t[1] = 32'h80000000; b_t[1] = 32'd31;
    sel_t[2] = 4'd2; a_t[2] = 32'hA5A5_1234; b_t[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      model(sel_t[i], a_t[i], b_t[i], er, eill, elat);
      do_op(sel_t[i], a_t[i], b_t[i], 0, res, ill, z, lat);
      tests_run++;
      if (res !== er) begin
        tests_failed++;
        $display("FAIL shift_result[%0d]: got %h want %h", i, res, er);
      end
      tests_run++;
      if (lat != elat) begin
        tests_failed++;
        $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, elat);
      end
    end
  endtask

  task automatic test_branch_codes();
    logic [31:0] res;
    logic        ill, z;
    int          lat;
    do_op(4'd10, 32'd5, 32'd5, 0, res, ill, z, lat);
    tests_run++;
    if (res !== 32'd1 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL is_equal: got %h zero=%b want 00000001 zero=0", res, z);
    end
    do_op(4'd12, 32'd1, 32'hFFFFFFFF, 0, res, ill, z, lat);
    tests_run++;
    if (res !== 32'd0 || z !== 1'b1) begin
      tests_failed++;
      $display("FAIL sgte_u: got %h zero=%b want 00000000 zero=1", res, z);
    end
    do_op(4'd11, 32'd1, 32'hFFFFFFFF, 0, res, ill, z, lat);
    tests_run++;
    if (res !== 32'd1 || z !== 1'b0) begin
      tests_failed++;
      $display("FAIL sgte_s: got %h zero=%b want 00000001 zero=0", res, z);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res;
    logic        ill, z;
    int          lat;
    for (int c = 14; c <= 15; c++) begin
      do_op(4'(c), $urandom, $urandom, 1, res, ill, z, lat);
      tests_run++;
      if (res !== 32'hDEADBEEF || ill !== 1'b1 || z !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_code_%0d: got %h ill=%b zero=%b want deadbeef ill=1 zero=0",
                 c, res, ill, z);
      end
    end
    do_op(4'd13, 32'h12345000, 32'hFFFF_FFFF, 0, res, ill, z, lat);
    tests_run++;
    if (res !== 32'h12345000 || ill !== 1'b0) begin
      tests_failed++;
      $display("FAIL in1_to_out: got %h ill=%b want 12345000 ill=0", res, ill);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sel_t[3];
    logic [31:0] a_t[3];
    logic [31:0] b_t[3];
    logic [31:0] er, exp_v;
    logic        eill;
    int          elat;
    sel_t[0] = 4'd1; a_t[0] = 32'd7;          b_t[0] = 32'd7;
    sel_t[1] = 4'd8; a_t[1] = 32'hFFFFFFFF;   b_t[1] = 32'd1;
    sel_t[2] = 4'd7; a_t[2] = 32'h0000F0F0;   b_t[2] = 32'h0000FFFF;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      aluselect = sel_t[i];
      in1       = a_t[i];
      in2       = b_t[i];
      model(sel_t[i], a_t[i], b_t[i], er, eill, elat);
      exp_q.push_back(er);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || result !== exp_v || zero !== (exp_v == 32'd0)) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got valid=%b %h zero=%b want valid=1 %h zero=%b",
                 i, out_valid, result, zero, exp_v, (exp_v == 32'd0));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluselect = 4'd0;
    in1       = 32'd1;
    in2       = 32'd1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b %h in_ready=%b want valid=1 00000002 in_ready=0",
                 i, out_valid, result, in_ready);
      end
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clk);
    end
    in1       = 32'd10;
    in2       = 32'd20;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || result !== 32'd30) begin
      tests_failed++;
      $display("FAIL backpressure_next: got valid=%b %h want valid=1 0000001e", out_valid, result);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    logic        ill, z;
    int          lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluselect = 4'd2;
    in1       = 32'd1;
    in2       = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_shift_busy: got valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_shift_reset: got valid=%b %h zero=%b in_ready=%b want 0 00000000 1 0",
               out_valid, result, zero, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd0, 32'd2, 32'd3, 0, res, ill, z, lat);
    tests_run++;
    if (res !== 32'd5 || lat != 1) begin
      tests_failed++;
      $display("FAIL after_reset_add: got %h lat=%0d want 00000005 lat=1", res, lat);
    end
  endtask

  task automatic test_random();
    logic [3:0]  sel;
    logic [31:0] a, b, res, er;
    logic        ill, z, eill;
    int          lat, elat;
    for (int n = 0; n < 250; n++) begin
      sel = 4'($urandom_range(0, 15));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      model(sel, a, b, er, eill, elat);
      do_op(sel, a, b, $urandom_range(0, 2), res, ill, z, lat);
      tests_run++;
      if (res !== er || ill !== eill || z !== (er == 32'd0) || lat != elat) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h ill=%b zero=%b lat=%0d want %h ill=%b zero=%b lat=%0d",
                 n, sel, a, b, res, ill, z, lat, er, eill, (er == 32'd0), elat);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_shifts();
    test_branch_codes();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
